// File: rtl/calc_engine.sv
// Multi-cycle add/sub/mul/div calculator with sequential double-dabble BCD output.
// Optional feature macro: CALC_OVERFLOW_EN (flag and blank results wider than DIGITS).
module calc_engine #(
   parameter int WIDTH  = 4,
   parameter int DIGITS = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   input  logic                  plus,
   input  logic                  minus,
   input  logic                  mul,
   input  logic                  div,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  neg,
   output logic                  err
);

   localparam int RW = 2 * WIDTH;
   localparam int ND = (RW * 30103 + 99999) / 100000;
   localparam int BW = 4 * ((ND > DIGITS) ? ND : DIGITS);
   localparam int CW = $clog2(RW + 1);

   typedef enum logic [1:0] {IDLE, EXEC, BCD, DONE} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   state_t              state_q, state_d;
   op_t                 op_q, op_d;
   logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
   logic [RW-1:0]       res_q, res_d, aux_q, aux_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [4*ND-1:0]     bcd_q, bcd_d;
   logic                neg_w_q, neg_w_d, err_w_q, err_w_d;
   logic [4*DIGITS-1:0] digits_q, digits_d;
   logic                neg_q, neg_d, err_q, err_d, done_q, done_d;

   logic [WIDTH:0]      rem_shift;
   logic [WIDTH-1:0]    quo;
   logic [4*ND-1:0]     bcd_adj;
   logic [BW-1:0]       bcd_ext;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         aux_q    <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         neg_w_q  <= 1'b0;
         err_w_q  <= 1'b0;
         digits_q <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         aux_q    <= aux_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         neg_w_q  <= neg_w_d;
         err_w_q  <= err_w_d;
         digits_q <= digits_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   // mul/div spend cycle 0 of EXEC on setup, then WIDTH iterations
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      aux_d     = aux_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      neg_w_d   = neg_w_q;
      err_w_d   = err_w_q;
      digits_d  = digits_q;
      neg_d     = neg_q;
      err_d     = err_q;
      done_d    = 1'b0;
      rem_shift = '0;
      quo       = '0;
      bcd_adj   = bcd_q;
      bcd_ext   = '0;

      case (state_q)
         IDLE: begin
            if (plus || minus || mul || div) begin
               state_d = EXEC;
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               neg_w_d = 1'b0;
               err_w_d = 1'b0;
               if (plus)       op_d = OP_ADD;
               else if (minus) op_d = OP_SUB;
               else if (mul)   op_d = OP_MUL;
               else            op_d = OP_DIV;
            end
         end

         EXEC: begin
            case (op_q)
               OP_ADD: begin
                  res_d   = RW'(a_q) + RW'(b_q);
                  state_d = BCD;
               end
               OP_SUB: begin
                  if (a_q < b_q) begin
                     res_d   = RW'(b_q - a_q);
                     neg_w_d = 1'b1;
                  end else begin
                     res_d   = RW'(a_q - b_q);
                  end
                  state_d = BCD;
               end
               OP_MUL: begin
                  if (cnt_q == '0) begin
                     res_d = '0;
                     aux_d = RW'(a_q);
                     cnt_d = CW'(1);
                  end else begin
                     if (b_q[0]) res_d = res_q + aux_q;
                     aux_d = aux_q << 1;
                     b_d   = b_q >> 1;
                     cnt_d = cnt_q + CW'(1);
                     if (cnt_q == CW'(WIDTH)) state_d = BCD;
                  end
               end
               default: begin
                  if (cnt_q == '0) begin
                     if (b_q == '0) begin
                        res_d   = '0;
                        err_w_d = 1'b1;
                        state_d = BCD;
                     end else begin
                        res_d = RW'(a_q);
                        aux_d = '0;
                        cnt_d = CW'(1);
                     end
                  end else begin
                     rem_shift = {aux_q[WIDTH-1:0], res_q[WIDTH-1]};
                     quo       = res_q[WIDTH-1:0] << 1;
                     if (rem_shift >= {1'b0, b_q}) begin
                        rem_shift = rem_shift - {1'b0, b_q};
                        quo[0]    = 1'b1;
                     end
                     aux_d = RW'(rem_shift);
                     res_d = RW'(quo);
                     cnt_d = cnt_q + CW'(1);
                     if (cnt_q == CW'(WIDTH)) state_d = BCD;
                  end
               end
            endcase
            if (state_d == BCD) begin
               cnt_d = '0;
               bcd_d = '0;
            end
         end

         BCD: begin
            for (int i = 0; i < ND; i++) begin
               if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
            bcd_d = {bcd_adj[4*ND-2:0], res_q[RW-1]};
            res_d = res_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(RW - 1)) state_d = DONE;
         end

         default: begin
            bcd_ext  = BW'(bcd_q);
            digits_d = bcd_ext[4*DIGITS-1:0];
            neg_d    = neg_w_q;
            err_d    = err_w_q;
`ifdef CALC_OVERFLOW_EN
            if ((bcd_ext >> (4 * DIGITS)) != '0) begin
               digits_d = '1;
               err_d    = 1'b1;
            end
`endif
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign digits = digits_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// Randomized self-checking bench for calc_engine; runs a DIGITS=4 and a DIGITS=2 instance side by side.
module tb_calc_engine;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  a = '0, b = '0;
   logic        plus = 1'b0, minus = 1'b0, mul = 1'b0, div = 1'b0;
   logic        busy4, done4, neg4, err4;
   logic [15:0] digits4;
   logic        busy2, done2, neg2, err2;
   logic [7:0]  digits2;

   int testsRun = 0;
   int testsFailed = 0;

   calc_engine #(.WIDTH(4), .DIGITS(4)) u_calc4 (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b),
      .plus(plus), .minus(minus), .mul(mul), .div(div),
      .busy(busy4), .done(done4), .digits(digits4), .neg(neg4), .err(err4)
   );

   calc_engine #(.WIDTH(4), .DIGITS(2)) u_calc2 (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b),
      .plus(plus), .minus(minus), .mul(mul), .div(div),
      .busy(busy2), .done(done2), .digits(digits2), .neg(neg2), .err(err2)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Arithmetic reference: ops = {plus, minus, mul, div}, highest bit wins
   task automatic model(input logic [3:0] ops, input int av, input int bv,
                        output int mag, output bit n, output bit e);
      n = 1'b0;
      e = 1'b0;
      if (ops[3])      mag = av + bv;
      else if (ops[2]) begin
         if (av < bv) begin mag = bv - av; n = 1'b1; end
         else mag = av - bv;
      end
      else if (ops[1]) mag = av * bv;
      else if (bv == 0) begin mag = 0; e = 1'b1; end
      else mag = av / bv;
   endtask

   task automatic expectDigits(input int mag, input int nd, input bit eIn,
                               output logic [31:0] d, output bit eOut);
      int m;
      int lim;
      m = mag;
      lim = 1;
      d = '0;
      for (int i = 0; i < nd; i++) begin
         d[4*i +: 4] = 4'(m % 10);
         m = m / 10;
         lim = lim * 10;
      end
      eOut = eIn;
`ifdef CALC_OVERFLOW_EN
      if (mag > lim - 1) begin
         d = 0;
         for (int i = 0; i < nd; i++) d[4*i +: 4] = 4'hF;
         eOut = 1'b1;
      end
`endif
   endtask

   task automatic applyStimulus(input logic [3:0] ops, input logic [3:0] av, input logic [3:0] bv,
                                input bit checkLat, input int busyDivAt);
      int n;
      int extra;
      bit got;
      int mag;
      bit en, ee, e4, e2;
      logic [31:0] d4, d2;
      int expLat;
      model(ops, int'(av), int'(bv), mag, en, ee);
      expectDigits(mag, 4, ee, d4, e4);
      expectDigits(mag, 2, ee, d2, e2);
      expLat = (ops[3] || ops[2]) ? 10 : 14;

      @(negedge clock);
      a = av;
      b = bv;
      {plus, minus, mul, div} = ops;
      @(posedge clock);
      #1;
      {plus, minus, mul, div} = 4'b0;
      checkOutput("busy_after_accept", 32'(busy4), 32'd1);

      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         if (busyDivAt != 0 && n == busyDivAt) begin
            a = 4'd12;
            b = 4'd3;
            div = 1'b1;
         end
         @(posedge clock);
         #1;
         n++;
         div = 1'b0;
         if (done4) got = 1'b1;
      end
      checkOutput("done_seen", 32'(got), 32'd1);
      if (checkLat) checkOutput("latency", 32'(n), 32'(expLat));
      checkOutput("done_dual", 32'(done2), 32'd1);
      checkOutput("digits4", 32'(digits4), d4);
      checkOutput("neg4", 32'(neg4), 32'(en));
      checkOutput("err4", 32'(err4), 32'(e4));
      checkOutput("digits2", 32'(digits2), d2);
      checkOutput("neg2", 32'(neg2), 32'(en));
      checkOutput("err2", 32'(err2), 32'(e2));

      @(posedge clock);
      #1;
      checkOutput("done_pulse_width", 32'(done4), 32'd0);
      checkOutput("busy_after_done", 32'(busy4), 32'd0);

      if (busyDivAt != 0) begin
         extra = 0;
         repeat (20) begin
            @(posedge clock);
            #1;
            if (done4) extra++;
         end
         checkOutput("no_extra_done", 32'(extra), 32'd0);
      end
   endtask

   initial begin
      logic [3:0] ops;
      logic [3:0] av, bv;

      #1;
      checkOutput("rst_busy", 32'(busy4), 32'd0);
      checkOutput("rst_done", 32'(done4), 32'd0);
      checkOutput("rst_digits", 32'(digits4), 32'd0);
      checkOutput("rst_neg_err", 32'({neg4, err4}), 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      applyStimulus(4'b1000, 4'd9, 4'd7, 1'b1, 0);
      applyStimulus(4'b0100, 4'd3, 4'd9, 1'b1, 0);
      applyStimulus(4'b0010, 4'd15, 4'd15, 1'b1, 0);
      applyStimulus(4'b0001, 4'd13, 4'd4, 1'b1, 0);
      applyStimulus(4'b0001, 4'd5, 4'd0, 1'b0, 0);
      applyStimulus(4'b1010, 4'd6, 4'd8, 1'b1, 3);
      applyStimulus(4'b0010, 4'd11, 4'd13, 1'b1, 0);

      // reset during a multiply must clear everything without a done
      @(negedge clock);
      a = 4'd15;
      b = 4'd14;
      mul = 1'b1;
      @(posedge clock);
      #1;
      mul = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy4), 32'd0);
      checkOutput("midrst_done", 32'(done4), 32'd0);
      checkOutput("midrst_digits", 32'(digits4), 32'd0);
      checkOutput("midrst_neg_err", 32'({neg4, err4}), 32'd0);
      begin
         int sawDone;
         sawDone = 0;
         repeat (20) begin
            @(posedge clock);
            #1;
            if (done4) sawDone++;
         end
         checkOutput("midrst_no_done", 32'(sawDone), 32'd0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(4'b0010, 4'd2, 4'd3, 1'b1, 0);

      for (int i = 0; i < 30; i++) begin
         ops = 4'($urandom_range(1, 15));
         av = 4'($urandom_range(0, 15));
         bv = 4'($urandom_range(0, 15));
         applyStimulus(ops, av, bv, !(ops == 4'b0001 && bv == 4'd0), 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
